alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 28 ++
 rtl/alu_pipe_core.sv | 112 +++++++++++
 rtl/alu_pipe.sv | 178 +++++++++++++++++
 tb/tb_alu_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the pipelined ALU.
//   - 4-bit op-code constants used by alu_core and alu_pipe
//   - FSM state enum for the handshake/multiply controller
//   - is_legal_op helper: op codes above OP_MUL are reserved
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// alu_core: purely combinational single-cycle ALU with flag generation.
// Ports:
//   a, b      operands (WIDTH bits); shift amount is b[SHAMT_W-1:0]
//   op        4-bit op code (alu_pipe_pkg constants)
//   result    operation result
//   zero, carry, negative, overflow, err  status flags
// OP_MUL is not computed here (the parent iterates it); it reports a zero
// result with err=0 so the parent can ignore this block for that op.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  logic [SHAMT_W-1:0] shamt_s;
  logic               shamt_big_s;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     shr_s;
  logic [WIDTH:0]     sra_s;
  logic [WIDTH-1:0]   res_s;
  logic               carry_s;
  logic               ovf_s;
  logic               err_s;

  assign shamt_s     = b[SHAMT_W-1:0];
  // Only reachable when WIDTH is not a power of two.
  assign shamt_big_s = ({{(32-SHAMT_W){1'b0}}, shamt_s} >= 32'(WIDTH));

  // One extra bit on each side captures carry/borrow and the last bit
  // shifted out, so no separate carry logic is needed per op.
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};
  assign shl_s = {1'b0, a} << shamt_s;
  assign shr_s = {a, 1'b0} >> shamt_s;
  assign sra_s = $signed({a, 1'b0}) >>> shamt_s;

  // Op decode: result, carry, overflow and err selection.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    err_s   = 1'b0;
    case (op)
      OP_ADD: begin
        res_s   = add_s[WIDTH-1:0];
        carry_s = add_s[WIDTH];
        ovf_s   = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_s   = sub_s[WIDTH-1:0];
        carry_s = sub_s[WIDTH];  // borrow, i.e. a < b unsigned
        ovf_s   = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
      end
      OP_AND: res_s = a & b;
      OP_OR:  res_s = a | b;
      OP_XOR: res_s = a ^ b;
      OP_NOT: res_s = ~a;
      OP_SHL: begin
        if (shamt_big_s) begin
          res_s   = {WIDTH{1'b0}};
          carry_s = 1'b0;
        end else begin
          res_s   = shl_s[WIDTH-1:0];
          carry_s = shl_s[WIDTH];
        end
      end
      OP_SHR: begin
        if (shamt_big_s) begin
          res_s   = {WIDTH{1'b0}};
          carry_s = 1'b0;
        end else begin
          res_s   = shr_s[WIDTH:1];
          carry_s = shr_s[0];
        end
      end
      OP_SRA: begin
        if (shamt_big_s) begin
          res_s   = {WIDTH{a[MSB]}};
          carry_s = 1'b0;
        end else begin
          res_s   = sra_s[WIDTH:1];
          carry_s = sra_s[0];
        end
      end
      OP_MUL: res_s = {WIDTH{1'b0}};
      default: err_s = 1'b1;
    endcase
  end

  assign result   = res_s;
  assign zero     = (res_s == {WIDTH{1'b0}});
  assign negative = res_s[MSB];
  assign carry    = carry_s;
  assign overflow = ovf_s;
  assign err      = err_s;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready wrapped ALU with an iterative shift-add multiplier.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake for a, b, op
//   a, b, op              operands and op code
//   out_valid/out_ready   result handshake
//   result, zero, carry, negative, overflow, err   registered result/flags
//   busy                  controller not idle
// Non-MUL ops complete in one cycle; MUL spends WIDTH cycles in ST_MUL.
// While a result is being consumed a new request may be accepted on the
// same edge, giving one result per cycle for back-to-back single-cycle ops.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             err,
  output logic             busy
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             negative_q, negative_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] core_result_s;
  logic             core_zero_s, core_carry_s, core_negative_s;
  logic             core_overflow_s, core_err_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] acc_step_s;

  alu_core #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_core (
    .a       (a),
    .b       (b),
    .op      (op),
    .result  (core_result_s),
    .zero    (core_zero_s),
    .carry   (core_carry_s),
    .negative(core_negative_s),
    .overflow(core_overflow_s),
    .err     (core_err_s)
  );

  // A pending result being consumed this cycle frees the slot immediately.
  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;
  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state, multiplier datapath and result/flag capture.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (op == OP_MUL) begin
            state_d  = ST_MUL;
            acc_d    = {WIDTH{1'b0}};
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = {CNT_W{1'b0}};
          end else begin
            state_d    = ST_DONE;
            result_d   = core_result_s;
            zero_d     = core_zero_s;
            carry_d    = core_carry_s;
            negative_d = core_negative_s;
            overflow_d = core_overflow_s;
            err_d      = core_err_s;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_MUL: begin
        acc_d    = acc_step_s;
        mcand_d  = mcand_q << 1'b1;
        mplier_d = mplier_q >> 1'b1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_DONE;
          result_d   = acc_step_s;
          zero_d     = (acc_step_s == {WIDTH{1'b0}});
          negative_d = acc_step_s[WIDTH-1];
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          err_d      = 1'b0;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= {WIDTH{1'b0}};
      mcand_q    <= {WIDTH{1'b0}};
      mplier_q   <= {WIDTH{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      result_q   <= {WIDTH{1'b0}};
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vector table,
// hand-written multi-cycle sequences and random ops against a reference model.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = 8'h00;
  logic [W-1:0] b_i = 8'h00;
  logic [3:0]   op_i = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, carry, negative, overflow, err, busy;
  logic [4:0]   flags;

  int n_chk  = 0;
  int n_pass = 0;

  assign flags = {zero, carry, negative, overflow, err};

  alu_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_i),
    .b        (b_i),
    .op       (op_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] fl;   // {zero, carry, negative, overflow, err}
    int         lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Behavioural model from the op definitions, using plain integer arithmetic.
  task automatic ref_op(input int op, input int a, input int b,
                        output logic [7:0] res, output logic [4:0] fl);
    int r, sa, sb, s, sh;
    logic c, v, e;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    r = 0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      0: begin s = a + b; r = s % 256; c = (s > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      1: begin r = (a - b + 256) % 256; c = (a < b); s = sa - sb; v = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << sh) % 256; c = (sh != 0) && ((((a << sh) / 256) % 2) != 0); end
      6: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
      7: r = 255 - a;
      8: begin r = (sa >>> sh) & 255; c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
      9: r = (a * b) % 256;
      default: e = 1'b1;
    endcase
    res = r[7:0];
    fl  = {(r == 0), c, r[7], v, e};
  endtask

  // Issue one op from idle, scramble inputs after accept, wait for the
  // result (bounded), sample it, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [4:0] fl,
                        output int lat, output bit rdy_bad);
    rdy_bad = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op_i = op; a_i = a; b_i = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_i = 4'($urandom); a_i = 8'($urandom); b_i = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    fl  = flags;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] res, eres;
    logic [4:0] fl, efl;
    int         lat;
    bit         rdy_bad;
    int         op, ra, rb;
    logic [7:0] sa_k, sb_k;

    vecs[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 5'b00110, 1};
    vecs[1]  = '{4'd1,  8'h03, 8'h05, 8'hFE, 5'b01100, 1};
    vecs[2]  = '{4'd1,  8'h33, 8'h33, 8'h00, 5'b10000, 1};
    vecs[3]  = '{4'd9,  8'h0D, 8'h0B, 8'h8F, 5'b00100, 9};
    vecs[4]  = '{4'd8,  8'h90, 8'h03, 8'hF2, 5'b00100, 1};
    vecs[5]  = '{4'd5,  8'h81, 8'h01, 8'h02, 5'b01000, 1};
    vecs[6]  = '{4'd12, 8'h5A, 8'h33, 8'h00, 5'b10001, 1};
    vecs[7]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 5'b00000, 1};
    vecs[8]  = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 5'b00100, 1};
    vecs[9]  = '{4'd4,  8'hAA, 8'hFF, 8'h55, 5'b00000, 1};
    vecs[10] = '{4'd7,  8'h0F, 8'h77, 8'hF0, 5'b00100, 1};
    vecs[11] = '{4'd6,  8'h85, 8'h03, 8'h10, 5'b01000, 1};
    vecs[12] = '{4'd0,  8'hFF, 8'h01, 8'h00, 5'b11000, 1};
    vecs[13] = '{4'd1,  8'h80, 8'h01, 8'h7F, 5'b00010, 1};
    vecs[14] = '{4'd5,  8'h55, 8'h00, 8'h55, 5'b00000, 1};
    vecs[15] = '{4'd9,  8'hFF, 8'hFF, 8'h01, 5'b00000, 9};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("in_ready after reset", 32'(in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, fl, lat, rdy_bad);
      chk($sformatf("vec%0d result", i), 32'(res), 32'(vecs[i].res));
      chk($sformatf("vec%0d flags", i), 32'(fl), 32'(vecs[i].fl));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].op == 4'd9) chk($sformatf("vec%0d in_ready low in MUL", i), 32'(rdy_bad), 32'd0);
    end

    // Hold result for 5 cycles with a competing request present
    @(negedge clk);
    in_valid = 1'b1; op_i = 4'd0; a_i = 8'h10; b_i = 8'h20; out_ready = 1'b0;
    @(posedge clk); #1;
    a_i = 8'h01; b_i = 8'h01;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d result", i), 32'(result), 32'h30);
      chk($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end

    // Stream 4 ADDs back-to-back: one result per cycle
    for (int k = 0; k < 4; k++) begin
      sa_k = 8'(k * 17 + 3);
      sb_k = 8'(k * 40 + 9);
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; op_i = 4'd0; a_i = sa_k; b_i = sb_k;
      @(posedge clk); #1;
      chk($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d result", k), 32'(result), 32'((k * 17 + 3 + k * 40 + 9) % 256));
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stream drain busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // Reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; op_i = 4'd9; a_i = 8'h0D; b_i = 8'h0B;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-MUL busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-MUL rst out_valid", 32'(out_valid), 32'd0);
    chk("mid-MUL rst busy", 32'(busy), 32'd0);
    chk("mid-MUL rst result", 32'(result), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("mid-MUL in_ready after release", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("abandoned MUL no output", 32'(out_valid), 32'd0);
    run_op(4'd0, 8'h02, 8'h03, res, fl, lat, rdy_bad);
    chk("post-reset ADD result", 32'(res), 32'h05);

    // Random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      ref_op(op, ra, rb, eres, efl);
      run_op(4'(op), 8'(ra), 8'(rb), res, fl, lat, rdy_bad);
      chk($sformatf("rand%0d op%0d a%0h b%0h result", i, op, ra, rb), 32'(res), 32'(eres));
      chk($sformatf("rand%0d op%0d a%0h b%0h flags", i, op, ra, rb), 32'(fl), 32'(efl));
      chk($sformatf("rand%0d op%0d latency", i, op), 32'(lat), (op == 9) ? 32'd9 : 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
